// File: rtl/scr1_sha256_sched_ctrl.sv
// SHA-256 block sequencer: message buffer, W schedule, K ROM, go/done status.
// go -> dp_init (1 cycle) -> ROUNDS round cycles (each dp_stall cycle adds one) -> dp_final_add -> done.
module scr1_sha256_sched_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        abort,
    input  logic        msg_wr,
    input  logic [3:0]  msg_idx,
    input  logic [31:0] msg_wdata,
    input  logic        dp_stall,
    output logic        busy,
    output logic        done,
    output logic        msg_wr_err,
    output logic        dp_init,
    output logic        dp_round_en,
    output logic [5:0]  dp_round_idx,
    output logic [31:0] dp_k,
    output logic [31:0] dp_w,
    output logic        dp_final_add
);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_ROUND, ST_FINAL} state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  t;
    logic [5:0]  t_nxt;
    logic        done_nxt;
    logic        err_nxt;
    logic        sched_we;
    logic [31:0] msg_buf [16];
    logic [3:0]  idx_m2;
    logic [3:0]  idx_m7;
    logic [3:0]  idx_m15;
    logic [3:0]  idx_m16;
    logic [31:0] w_cur;

    // The buffer is a 16-word sliding window: slot t&15 holds W[t-16] until overwritten by W[t].
    assign idx_m2  = t[3:0] - 4'd2;
    assign idx_m7  = t[3:0] - 4'd7;
    assign idx_m15 = t[3:0] - 4'd15;
    assign idx_m16 = t[3:0];

    always_comb begin
        w_cur = msg_buf[idx_m16];
        if (t >= 6'd16) begin
            w_cur = sig1(msg_buf[idx_m2]) + msg_buf[idx_m7] + sig0(msg_buf[idx_m15]) + msg_buf[idx_m16];
        end
    end

    assign dp_w         = w_cur;
    assign dp_k         = K_ROM[t];
    assign dp_round_idx = t;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nxt    = state;
        t_nxt        = t;
        done_nxt     = done;
        err_nxt      = msg_wr_err;
        sched_we     = 1'b0;
        dp_init      = 1'b0;
        dp_round_en  = 1'b0;
        dp_final_add = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go && !abort) begin
                    state_nxt = ST_INIT;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            ST_INIT: begin
                dp_init   = 1'b1;
                state_nxt = ST_ROUND;
                t_nxt     = 6'd0;
            end
            ST_ROUND: begin
                dp_round_en = !dp_stall;
                if (!dp_stall) begin
                    sched_we = (t >= 6'd16);
                    if (t == LAST_T) begin
                        state_nxt = ST_FINAL;
                        t_nxt     = 6'd0;
                    end else begin
                        t_nxt = t + 6'd1;
                    end
                end
            end
            ST_FINAL: begin
                dp_final_add = !abort;
                state_nxt    = ST_IDLE;
                done_nxt     = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE) begin
            if (msg_wr || go) begin
                err_nxt = 1'b1;
            end
            if (abort) begin
                state_nxt = ST_IDLE;
                t_nxt     = 6'd0;
                done_nxt  = 1'b0;
                sched_we  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            t          <= 6'd0;
            done       <= 1'b0;
            msg_wr_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            t          <= t_nxt;
            done       <= done_nxt;
            msg_wr_err <= err_nxt;
        end
    end

    // Software writes only land in IDLE; rounds own the buffer otherwise.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && msg_wr) begin
            msg_buf[msg_idx] <= msg_wdata;
        end else if (sched_we) begin
            msg_buf[idx_m16] <= w_cur;
        end
    end

endmodule

// File: tb/tb_scr1_sha256_sched_ctrl.sv
// Scoreboard bench for scr1_sha256_sched_ctrl: expected strobes are queued at go, a negedge monitor pops and compares.
module tb_scr1_sha256_sched_ctrl;

    localparam int ROUNDS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        abort;
    logic        msg_wr;
    logic [3:0]  msg_idx;
    logic [31:0] msg_wdata;
    logic        dp_stall;
    logic        busy;
    logic        done;
    logic        msg_wr_err;
    logic        dp_init;
    logic        dp_round_en;
    logic [5:0]  dp_round_idx;
    logic [31:0] dp_k;
    logic [31:0] dp_w;
    logic        dp_final_add;

    scr1_sha256_sched_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .msg_wr(msg_wr), .msg_idx(msg_idx), .msg_wdata(msg_wdata), .dp_stall(dp_stall),
        .busy(busy), .done(done), .msg_wr_err(msg_wr_err),
        .dp_init(dp_init), .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx),
        .dp_k(dp_k), .dp_w(dp_w), .dp_final_add(dp_final_add)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int          kind;
        int          rel;
        int          idx;
        logic [31:0] k;
        logic [31:0] w;
    } ev_t;

    ev_t         exp_q[$];
    int          base = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] msg    [16];
    logic [31:0] wexp   [64];
    logic [31:0] obs_w  [64];
    logic [31:0] obs_k  [64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rel(input int r);
        int n;
        n = 0;
        while ((cyc - base) < r && n < 500) begin
            step();
            n++;
        end
    endtask

    // Reference schedule in the textbook 64-entry form; rounds at or after t=20 shift by the stall length.
    task automatic start_block(input int stall_n, input int stop_t);
        ev_t e;
        for (int i = 0; i < 16; i++) wexp[i] = msg[i];
        for (int i = 16; i < 64; i++) begin
            wexp[i] = (rotr(wexp[i-2], 17) ^ rotr(wexp[i-2], 19) ^ (wexp[i-2] >> 10)) + wexp[i-7]
                    + (rotr(wexp[i-15], 7) ^ rotr(wexp[i-15], 18) ^ (wexp[i-15] >> 3)) + wexp[i-16];
        end
        e.kind = 0; e.rel = 1; e.idx = 0; e.k = 32'h0; e.w = 32'h0;
        exp_q.push_back(e);
        for (int i = 0; i <= stop_t; i++) begin
            e.kind = 1; e.rel = i + 2 + ((i >= 20) ? stall_n : 0);
            e.idx = i; e.k = K_TB[i]; e.w = wexp[i];
            exp_q.push_back(e);
        end
        if (stop_t == ROUNDS - 1) begin
            e.kind = 2; e.rel = ROUNDS + 2 + stall_n; e.idx = 0; e.k = 32'h0; e.w = 32'h0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            msg_wr = 1'b1; msg_idx = 4'(i); msg_wdata = msg[i];
        end
        step();
        msg_idx = 4'd15; msg_wdata = msg[15]; go = 1'b1;
        step();
        msg_wr = 1'b0; go = 1'b0;
        base = cyc - 1;
    endtask

    task automatic wait_done(input int exp_rel);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_cycle", cyc - base, exp_rel);
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        int  kind;
        int  rel;
        if (dp_init || dp_round_en || dp_final_add) begin
            kind = dp_final_add ? 2 : (dp_round_en ? 1 : 0);
            rel  = cyc - base;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected no strobe", kind, rel);
            end else begin
                e = exp_q.pop_front();
                if (kind != e.kind || rel != e.rel ||
                    (kind == 1 && (int'(dp_round_idx) != e.idx || dp_k !== e.k || dp_w !== e.w))) begin
                    errors++;
                    $display("FAIL strobe: got kind %0d cyc %0d t %0d k %h w %h, expected kind %0d cyc %0d t %0d k %h w %h",
                             kind, rel, dp_round_idx, dp_k, dp_w, e.kind, e.rel, e.idx, e.k, e.w);
                end
            end
            if (dp_round_en) begin
                obs_w[dp_round_idx] = dp_w;
                obs_k[dp_round_idx] = dp_k;
            end
        end
    end

    initial begin
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; msg_wr = 1'b0;
        msg_idx = 4'd0; msg_wdata = 32'h0; dp_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(msg_wr_err), 32'd0);
        chk("rst_strobes", {29'd0, dp_init, dp_round_en, dp_final_add}, 32'd0);
        chk("rst_idx", 32'(dp_round_idx), 32'd0);
        chk("rst_k", dp_k, 32'h428a2f98);

        // Test 1: "abc" block; the last word is written in the same cycle as go.
        load_abc();
        start_block(0, ROUNDS - 1);
        chk("init_w0", dp_w, 32'h61626380);
        chk("busy_after_go", 32'(busy), 32'd1);
        goto_rel(ROUNDS + 2);
        chk("done_before_final", 32'(done), 32'd0);
        wait_done(ROUNDS + 3);
        chk("w0", obs_w[0], 32'h61626380);
        chk("w16", obs_w[16], 32'h61626380);
        chk("w17", obs_w[17], 32'h000F0000);
        chk("k0", obs_k[0], 32'h428a2f98);
        chk("k63", obs_k[63], 32'hc67178f2);

        // Test 2: 3-cycle stall at t=20.
        load_abc();
        start_block(3, ROUNDS - 1);
        goto_rel(22);
        dp_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #2;
            chk("stall_idx", 32'(dp_round_idx), 32'd20);
            chk("stall_en", 32'(dp_round_en), 32'd0);
            chk("stall_w", dp_w, wexp[20]);
            chk("stall_k", dp_k, K_TB[20]);
            step();
        end
        dp_stall = 1'b0;
        wait_done(ROUNDS + 6);

        // Test 3: msg_wr and go while busy.
        load_abc();
        start_block(0, ROUNDS - 1);
        goto_rel(5);
        msg_wr = 1'b1; msg_idx = 4'd0; msg_wdata = 32'hdeadbeef; go = 1'b1;
        step();
        msg_wr = 1'b0; go = 1'b0;
        chk("err_set", 32'(msg_wr_err), 32'd1);
        wait_done(ROUNDS + 3);
        chk("err_sticky", 32'(msg_wr_err), 32'd1);

        // Test 4: abort at t=30, then a clean block.
        load_abc();
        start_block(0, 30);
        chk("err_cleared", 32'(msg_wr_err), 32'd0);
        chk("done_cleared", 32'(done), 32'd0);
        goto_rel(32);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_idx", 32'(dp_round_idx), 32'd0);
        repeat (10) step();
        chk("abort_done_later", 32'(done), 32'd0);
        load_abc();
        start_block(0, ROUNDS - 1);
        wait_done(ROUNDS + 3);

        // Test 5: reset at t=40, then a block with a different message.
        load_abc();
        start_block(0, 39);
        goto_rel(42);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_strobes", {29'd0, dp_init, dp_round_en, dp_final_add}, 32'd0);
        chk("arst_idx", 32'(dp_round_idx), 32'd0);
        chk("arst_k", dp_k, 32'h428a2f98);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        load_abc();
        msg[1] = 32'h12345678;
        msg[7] = 32'h9abcdef0;
        start_block(0, ROUNDS - 1);
        wait_done(ROUNDS + 3);

        // Test 6: go and abort together in IDLE.
        step();
        go = 1'b1; abort = 1'b1;
        step();
        go = 1'b0; abort = 1'b0;
        chk("goabort_busy", 32'(busy), 32'd0);
        chk("goabort_done", 32'(done), 32'd1);
        repeat (5) step();
        chk("goabort_busy_later", 32'(busy), 32'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_sha256_sched_ctrl.md
Name: scr1_sha256_sched_ctrl

Overview:
- Sequencer for the SHA-256 compression datapath in the SCR1 accelerator.
- Holds the 16-word message buffer, which software loads through the register file.
- On a go pulse it drives one compression block: init working vars, ROUNDS rounds, final add. Each round supplies the round index, K constant and expanded message word W.
- The round datapath (a..h arithmetic) is external; this block owns sequencing, message schedule, K ROM and go/done status.

Parameters:
ROUNDS, 64, number of compression rounds; legal 17..64 (values below 64 are for fast simulation only).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
go  in  1  one-cycle start pulse (register-file write to control word)
abort  in  1  one-cycle cancel pulse
msg_wr  in  1  message word write strobe
msg_idx  in  4  message word index 0..15
msg_wdata  in  32  message word, big-endian word already assembled
dp_stall  in  1  datapath cannot accept a round this cycle
busy  out  1  block in progress (INIT, ROUND or FINAL)
done  out  1  sticky completion flag
msg_wr_err  out  1  sticky: msg_wr or go arrived while busy
dp_init  out  1  load working vars a..h from state0..7
dp_round_en  out  1  datapath executes one round with dp_k/dp_w
dp_round_idx  out  6  current round t
dp_k  out  32  K[t]
dp_w  out  32  W[t]
dp_final_add  out  1  state_i <= state_i + working var i

Behaviour:
- Reset values: FSM=IDLE, t=0, busy=0, done=0, msg_wr_err=0, dp_* strobes=0, dp_round_idx=0, dp_k=K[0], dp_w=buf[0]. The message buffer is not reset.
- FSM states:
  - IDLE: go -> INIT; done cleared on the same edge.
  - INIT: dp_init=1 for exactly one cycle -> ROUND with t=0.
  - ROUND: dp_round_en = ~dp_stall. On a non-stalled cycle t increments. The cycle with t=ROUNDS-1 and ~dp_stall -> FINAL.
  - FINAL: dp_final_add=1 for one cycle -> IDLE, done<=1.
- Latency with no stalls:
  - go sampled at edge 0.
  - dp_init high in cycle 1.
  - Rounds in cycles 2..ROUNDS+1.
  - dp_final_add in cycle ROUNDS+2.
  - done visible from cycle ROUNDS+3. That is 67 cycles for ROUNDS=64.
  - Each stall cycle adds exactly one cycle.
- dp_k, dp_w and dp_round_idx are combinational from t and the buffer. They are valid whenever FSM=ROUND, and are held stable during a stall.
- Message schedule:
  - t<16: W=buf[t].
  - t>=16: W = σ1(buf[(t-2)&15]) + buf[(t-7)&15] + σ0(buf[(t-15)&15]) + buf[t&15], mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - On each non-stalled round with t>=16, buf[t&15] <= W.
  - After a block the buffer holds W[ROUNDS-16..ROUNDS-1], so software must reload all 16 words before the next go.
- K: 64-entry constant ROM indexed by t, e.g. K[0]=0x428a2f98, K[63]=0xc67178f2.
- msg_wr in IDLE: buf[msg_idx] <= msg_wdata next edge.
- msg_wr while busy: write ignored, msg_wr_err<=1.
- go while busy: ignored, msg_wr_err<=1.
- msg_wr_err is cleared only by a go accepted in IDLE.
- go and msg_wr in the same IDLE cycle: both take effect; the write lands before round 0 reads the buffer.
- abort:
  - From any non-IDLE state -> IDLE next edge. No dp_final_add is issued, done stays 0, t<=0.
  - abort in IDLE: no effect.
  - abort and go in the same cycle: abort wins, FSM stays IDLE, done unchanged.
- dp_stall is ignored outside ROUND; INIT and FINAL are never stretched.
- Asynchronous reset mid-block returns all state to reset values immediately, with no strobe glitches after reset release.

Test Plan:
1. Load "abc" block (buf[0]=0x61626380, buf[1..14]=0, buf[15]=0x00000018), pulse go:
   - dp_init in cycle 1.
   - Round 0: dp_w=0x61626380, dp_k=0x428a2f98.
   - W[16]=0x61626380, W[17]=0x000F0000.
   - Round 63: dp_k=0xc67178f2.
   - dp_final_add in cycle 66, done=1 in cycle 67.
2. Same block with dp_stall high at t=20 for 3 cycles:
   - dp_round_idx=20 and dp_w held during the stall, dp_round_en=0.
   - done at cycle 70.
   - W sequence identical to test 1.
3. msg_wr and go pulsed while busy:
   - Buffer unchanged, no restart, msg_wr_err=1.
   - Next accepted go clears msg_wr_err.
4. abort at t=30:
   - IDLE next cycle, busy=0, done=0, no dp_final_add.
   - Subsequent reload plus go completes normally.
5. rst_n asserted at t=40:
   - busy/done/strobes 0 immediately.
   - After release, go works with a freshly loaded buffer.
6. go and abort in the same IDLE cycle -> FSM stays IDLE, no dp_init.
